// File: rtl/cache_mem_responder.sv
// Memory-side line responder for the cache refill/write-back port: clears its
// line storage after reset, then serves one read or write at a time with a fixed latency.
module cache_mem_responder #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              init_done,
    output logic              proto_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BUSY, ST_RESP} state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    op_write_q, op_write_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    init_done_q, init_done_d;
    logic                    proto_err_q, proto_err_d;
    logic                    ready_q, ready_d;
    logic [DATA_W-1:0]       rdata_q;

    logic [DATA_W-1:0]       line_mem [DEPTH];
    logic                    ram_we;
    logic [DEPTH_LOG2-1:0]   ram_waddr;
    logic [DATA_W-1:0]       ram_wd;
    logic                    ram_re;
    logic [DEPTH_LOG2-1:0]   ram_raddr;

    // The operation that commits on the edge entering RESP
    logic                    go_resp;
    logic                    c_write;
    logic [DEPTH_LOG2-1:0]   c_idx;
    logic [DATA_W-1:0]       c_wdata;

    // Upper address bits alias onto the stored lines
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        op_write_d  = op_write_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        init_done_d = init_done_q;
        proto_err_d = proto_err_q;
        ready_d     = 1'b0;
        go_resp     = 1'b0;
        c_write     = op_write_q;
        c_idx       = idx_q;
        c_wdata     = wdata_q;
        ram_we      = 1'b0;
        ram_waddr   = ptr_q;
        ram_wd      = '0;
        ram_re      = 1'b0;
        ram_raddr   = idx_q;

        case (state_q)
            ST_INIT: begin
                ram_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == DEPTH_LOG2'(DEPTH - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    op_write_d = mem_write;
                    idx_d      = mem_addr[DEPTH_LOG2-1:0];
                    wdata_d    = mem_wdata;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    if (mem_read && mem_write) begin
                        proto_err_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        go_resp = 1'b1;
                        c_write = mem_write;
                        c_idx   = mem_addr[DEPTH_LOG2-1:0];
                        c_wdata = mem_wdata;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    go_resp = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_resp) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            if (c_write) begin
                ram_we    = 1'b1;
                ram_waddr = c_idx;
                ram_wd    = c_wdata;
            end else begin
                ram_re    = 1'b1;
                ram_raddr = c_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            cnt_q       <= '0;
            op_write_q  <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
            proto_err_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            op_write_q  <= op_write_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            init_done_q <= init_done_d;
            proto_err_q <= proto_err_d;
            ready_q     <= ready_d;
        end
    end

    // Storage array: single write port, registered read; rdata is zero outside a read response
    always_ff @(posedge clk) begin
        if (ram_we && !proc_reset) begin
            line_mem[ram_waddr] <= ram_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            rdata_q <= '0;
        end else if (ram_re) begin
            rdata_q <= line_mem[ram_raddr];
        end else begin
            rdata_q <= '0;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign init_done = init_done_q;
    assign proto_err = proto_err_q;

endmodule
